// File: rtl/fb_pkg.sv
// Shared definitions for the double-buffered framebuffer.
// Contents:
//   FB_RD_LAT    - read latency from request to pixel_data / pixel_valid
//   clr_state_t  - clear-engine state encoding (IDLE=0, CLEAR=1)
//   fb_mem_size  - words per page for a WIDTH x HEIGHT frame
//   fb_addr_w    - minimum linear address width for one page
package fb_pkg;

  localparam int FB_RD_LAT = 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_t;

  function automatic int fb_mem_size(input int w, input int h);
    return w * h;
  endfunction

  function automatic int fb_addr_w(input int w, input int h);
    return $clog2(w * h);
  endfunction

endpackage

// File: rtl/simple_dual_ram.sv
// Simple dual-port RAM: one synchronous write port, one synchronous
// registered read port. No read enable; the read port samples every cycle.
// Ports:
//   wr_clk, wr_en, wr_addr, wr_data - write port
//   rd_clk, rd_addr, rd_data        - read port, data valid one edge later
module simple_dual_ram #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              wr_clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_clk,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  // NOTE: the array has no reset so it maps onto block RAM; contents
  // after power-up are whatever the storage holds.
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge wr_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge rd_clk) begin
    rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/framebuffer_dbuf.sv
// Double-buffered framebuffer. The display reads the front page by (x, y)
// with a 2-cycle registered pipeline; the host writes the back page by
// linear address. Page swaps wait for frame_start, and a clear engine can
// fill the back page with a solid colour (one word per cycle).
// Ports:
//   clk, rst                          - clock, async active-low reset
//   wr_en, wr_addr, wr_data, wr_ready - host write port (back page)
//   rd_en, rd_x, rd_y                 - display read request (front page)
//   pixel_data, pixel_valid           - read result, 2 cycles after request
//   frame_start, swap_req             - swap timing and request pulses
//   swap_pending, swap_done           - swap status
//   front_page                        - page currently displayed
//   clear_req, clear_color            - start a back-page fill
//   clear_busy                        - fill in progress
module framebuffer_dbuf
  import fb_pkg::*;
#(
  parameter int               WIDTH  = 640,
  parameter int               HEIGHT = 480,
  parameter int               PIX_W  = 8,
  parameter int               ADDR_W = fb_addr_w(WIDTH, HEIGHT),
  parameter logic [PIX_W-1:0] BLANK  = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [9:0]        rd_x,
  input  logic [9:0]        rd_y,
  output logic [PIX_W-1:0]  pixel_data,
  output logic              pixel_valid,
  input  logic              frame_start,
  input  logic              swap_req,
  output logic              swap_pending,
  output logic              swap_done,
  output logic              front_page,
  input  logic              clear_req,
  input  logic [PIX_W-1:0]  clear_color,
  output logic              clear_busy
);

  localparam int                 MEM_SIZE = fb_mem_size(WIDTH, HEIGHT);
  localparam int                 AW       = ADDR_W + 1;
  localparam logic [AW-1:0]      PAGE_SZ  = AW'(MEM_SIZE);
  localparam logic [ADDR_W-1:0]  LAST     = ADDR_W'(MEM_SIZE - 1);

  clr_state_t          state;
  logic [ADDR_W-1:0]   cnt;
  logic [PIX_W-1:0]    fill;

  logic [AW-1:0]       front_base, back_base;
  logic                rd_hit, wr_hit;
  logic [AW-1:0]       rd_addr;
  logic                ram_we;
  logic [AW-1:0]       ram_waddr;
  logic [PIX_W-1:0]    ram_wdata, ram_q;
  logic                rd_en_q, rd_hit_q;

  assign clear_busy = (state == ST_CLEAR);
  assign wr_ready   = ~clear_busy;

  assign front_base = front_page ? PAGE_SZ : '0;
  assign back_base  = front_page ? '0 : PAGE_SZ;

  // Out-of-range reads still present a legal address (the page base) so the
  // RAM is never indexed past its depth; the result is masked to BLANK.
  assign rd_hit  = (32'(rd_x) < WIDTH) && (32'(rd_y) < HEIGHT);
  assign rd_addr = rd_hit ? front_base + AW'(rd_y) * AW'(WIDTH) + AW'(rd_x)
                          : front_base;
  assign wr_hit  = 32'(wr_addr) < MEM_SIZE;

  // The clear engine owns the single write port while busy, which is exactly
  // when wr_ready is low, so host writes in that window are dropped.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_wdata = '0;
    if (clear_busy) begin
      ram_we    = 1'b1;
      ram_waddr = back_base + AW'(cnt);
      ram_wdata = fill;
    end else if (wr_en && wr_hit) begin
      ram_we    = 1'b1;
      ram_waddr = back_base + AW'(wr_addr);
      ram_wdata = wr_data;
    end
  end

  simple_dual_ram #(
    .DATA_W (PIX_W),
    .DEPTH  (2 * MEM_SIZE),
    .ADDR_W (AW)
  ) u_ram (
    .wr_clk  (clk),
    .wr_en   (ram_we),
    .wr_addr (ram_waddr),
    .wr_data (ram_wdata),
    .rd_clk  (clk),
    .rd_addr (rd_addr),
    .rd_data (ram_q)
  );

  // Read pipeline: the request (and the front page it used) is captured on
  // the first edge alongside the RAM read, the result lands on the second.
  // NOTE: sequential state uses non-blocking assignments so every register
  // sees pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_en_q     <= 1'b0;
      rd_hit_q    <= 1'b0;
      pixel_valid <= 1'b0;
      pixel_data  <= BLANK;
    end else begin
      rd_en_q     <= rd_en;
      rd_hit_q    <= rd_en && rd_hit;
      pixel_valid <= rd_en_q;
      pixel_data  <= rd_hit_q ? ram_q : BLANK;
    end
  end

  // Swap: a request arriving on the frame_start cycle applies immediately;
  // the swap is held off while the clear engine is writing the back page.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      front_page   <= 1'b0;
      swap_pending <= 1'b0;
      swap_done    <= 1'b0;
    end else begin
      swap_done <= 1'b0;
      if (frame_start && (swap_pending || swap_req) && !clear_busy) begin
        front_page   <= ~front_page;
        swap_pending <= 1'b0;
        swap_done    <= 1'b1;
      end else if (swap_req) begin
        swap_pending <= 1'b1;
      end
    end
  end

  // Clear engine: one word per cycle, cnt 0..MEM_SIZE-1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      fill  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_req) begin
            state <= ST_CLEAR;
            cnt   <= '0;
            fill  <= clear_color;
          end
        end
        ST_CLEAR: begin
          if (cnt == LAST) state <= ST_IDLE;
          else             cnt   <= cnt + ADDR_W'(1);
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_dbuf.sv
// Bench for framebuffer_dbuf: a full-size instance for the 640x480 address
// and range checks, and an 8x4 instance for clear, swap and randomized
// write/read traffic against a page-array model.
module tb_framebuffer_dbuf;

  localparam int SW = 8;
  localparam int SH = 4;
  localparam int SM = SW * SH;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        wr_en = 1'b0;
  logic [7:0]  wr_data = '0;
  logic [18:0] b_wr_addr = '0;
  logic [4:0]  s_wr_addr = '0;
  logic        rd_en = 1'b0;
  logic [9:0]  rd_x = '0, rd_y = '0;
  logic        frame_start = 1'b0, swap_req = 1'b0, s_clear_req = 1'b0;
  logic [7:0]  clear_color = '0;

  logic       b_wr_ready, b_pixel_valid, b_swap_pending, b_swap_done, b_front_page, b_clear_busy;
  logic [7:0] b_pixel_data;
  logic       s_wr_ready, s_pixel_valid, s_swap_pending, s_swap_done, s_front_page, s_clear_busy;
  logic [7:0] s_pixel_data;

  int total = 0;
  int bad   = 0;

  logic [7:0] mem_m [0:2*SM-1];
  int         front_m = 0;

  always #5 clk = ~clk;

  framebuffer_dbuf u_big (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(b_wr_addr), .wr_data(wr_data), .wr_ready(b_wr_ready),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .pixel_data(b_pixel_data), .pixel_valid(b_pixel_valid),
    .frame_start(frame_start), .swap_req(swap_req),
    .swap_pending(b_swap_pending), .swap_done(b_swap_done), .front_page(b_front_page),
    .clear_req(1'b0), .clear_color(clear_color), .clear_busy(b_clear_busy)
  );

  framebuffer_dbuf #(.WIDTH(SW), .HEIGHT(SH), .ADDR_W(5)) u_small (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(s_wr_addr), .wr_data(wr_data), .wr_ready(s_wr_ready),
    .rd_en(rd_en), .rd_x(rd_x), .rd_y(rd_y),
    .pixel_data(s_pixel_data), .pixel_valid(s_pixel_valid),
    .frame_start(frame_start), .swap_req(swap_req),
    .swap_pending(s_swap_pending), .swap_done(s_swap_done), .front_page(s_front_page),
    .clear_req(s_clear_req), .clear_color(clear_color), .clear_busy(s_clear_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Fill the small instance's back page; checks busy/ready shape, drops a
  // host write mid-fill, optionally tries a swap while busy.
  task automatic run_clear(input logic [7:0] c, input bit mid_swap, input string tag);
    int busy_bad = 0;
    int ready_bad = 0;
    bit exp_busy;
    s_clear_req = 1'b1;
    clear_color = c;
    tick();
    s_clear_req = 1'b0;
    clear_color = ~c;
    for (int i = 0; i < 40; i++) begin
      exp_busy = (i < SM);
      if (s_clear_busy !== exp_busy)  busy_bad++;
      if (s_wr_ready !== !exp_busy)   ready_bad++;
      if (i == 5) begin wr_en = 1'b1; s_wr_addr = 5'd3; wr_data = 8'hFF; end
      if (i == 6) wr_en = 1'b0;
      if (mid_swap) begin
        if (i == 2) swap_req = 1'b1;
        if (i == 3) begin swap_req = 1'b0; frame_start = 1'b1; end
        if (i == 4) frame_start = 1'b0;
        if (i == 6) begin
          check({tag, "_busy_pend"},  32'(s_swap_pending), 32'd1);
          check({tag, "_busy_front"}, 32'(s_front_page),   32'(front_m));
          check({tag, "_busy_done"},  32'(s_swap_done),    32'd0);
        end
      end
      tick();
    end
    check({tag, "_busy_shape"},  32'(busy_bad),  32'd0);
    check({tag, "_ready_shape"}, 32'(ready_bad), 32'd0);
    for (int a = 0; a < SM; a++) mem_m[(1 - front_m) * SM + a] = c;
  endtask

  // swap_req and frame_start on the same cycle: toggle on that edge.
  task automatic swap_now(input string tag);
    swap_req = 1'b1;
    frame_start = 1'b1;
    tick();
    swap_req = 1'b0;
    frame_start = 1'b0;
    check({tag, "_front"}, 32'(s_front_page), 32'(front_m ^ 1));
    check({tag, "_done"},  32'(s_swap_done),  32'd1);
    front_m ^= 1;
    tick();
    check({tag, "_done_clr"}, 32'(s_swap_done), 32'd0);
  endtask

  // Back-to-back reads of the small instance, one per cycle.
  task automatic read_burst(input int n, input bit rnd, input string tag);
    logic [7:0] exp_d [$];
    bit         exp_v [$];
    int         err_d = 0;
    int         err_v = 0;
    logic [7:0] d;
    bit         v;
    for (int i = 0; i <= n; i++) begin
      if (i < n) begin
        if (rnd) begin
          rd_en = ($urandom_range(0, 3) != 0);
          rd_x  = 10'($urandom_range(0, SW + 1));
          rd_y  = 10'($urandom_range(0, SH + 1));
        end else begin
          rd_en = 1'b1;
          rd_x  = 10'(i % SW);
          rd_y  = 10'(i / SW);
        end
        exp_v.push_back(rd_en);
        if (rd_en && int'(rd_x) < SW && int'(rd_y) < SH)
          exp_d.push_back(mem_m[front_m * SM + int'(rd_y) * SW + int'(rd_x)]);
        else
          exp_d.push_back(8'h00);
      end else begin
        rd_en = 1'b0;
      end
      tick();
      if (i >= 1) begin
        d = exp_d.pop_front();
        v = exp_v.pop_front();
        if (s_pixel_data !== d)  err_d++;
        if (s_pixel_valid !== v) err_v++;
      end
    end
    check({tag, "_data"},  32'(err_d), 32'd0);
    check({tag, "_valid"}, 32'(err_v), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int bx [4] = '{5, 640, 0, 639};
    int by [4] = '{1, 0, 480, 479};
    bit be [4] = '{1, 1, 1, 0};
    logic [7:0] bd [4] = '{8'h5A, 8'h00, 8'h00, 8'h00};
    logic [7:0] c2;
    int         a;

    // Reset state
    repeat (3) tick();
    check("rst_front",   32'(b_front_page),   32'd0);
    check("rst_pend",    32'(b_swap_pending), 32'd0);
    check("rst_done",    32'(b_swap_done),    32'd0);
    check("rst_busy",    32'(s_clear_busy),   32'd0);
    check("rst_ready",   32'(s_wr_ready),     32'd1);
    check("rst_valid",   32'(b_pixel_valid),  32'd0);
    check("rst_pixel",   32'(b_pixel_data),   32'h00);
    rst = 1'b1;
    tick();

    // 1: write 645 on back page, swap at frame_start, read (5,1)
    wr_en = 1'b1; wr_data = 8'h5A; b_wr_addr = 19'd645; s_wr_addr = '0;
    tick();
    wr_en = 1'b0;
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("t1_pend_set",   32'(b_swap_pending), 32'd1);
    check("t1_no_toggle",  32'(b_front_page),   32'd0);
    tick();
    check("t1_pend_hold",  32'(b_swap_pending), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t1_front",      32'(b_front_page),   32'd1);
    check("t1_done",       32'(b_swap_done),    32'd1);
    check("t1_pend_clr",   32'(b_swap_pending), 32'd0);
    front_m = 1;
    tick();
    check("t1_done_once",  32'(b_swap_done),    32'd0);
    rd_en = 1'b1; rd_x = 10'd5; rd_y = 10'd1;
    tick();
    rd_en = 1'b0;
    check("t1_lat1_valid", 32'(b_pixel_valid),  32'd0);
    tick();
    check("t1_lat2_valid", 32'(b_pixel_valid),  32'd1);
    check("t1_lat2_data",  32'(b_pixel_data),   32'h5A);
    tick();
    check("t1_lat3_valid", 32'(b_pixel_valid),  32'd0);

    // 2: dropped write past the page, then range and enable checks
    wr_en = 1'b1; wr_data = 8'hC3; b_wr_addr = 19'(307200 + 645);
    tick();
    wr_en = 1'b0;
    for (int i = 0; i <= 4; i++) begin
      if (i < 4) begin
        rd_en = be[i]; rd_x = 10'(bx[i]); rd_y = 10'(by[i]);
      end else begin
        rd_en = 1'b0;
      end
      tick();
      if (i >= 1) begin
        check($sformatf("t2_valid%0d", i - 1), 32'(b_pixel_valid), 32'(be[i - 1]));
        check($sformatf("t2_data%0d", i - 1),  32'(b_pixel_data),  32'(bd[i - 1]));
      end
    end

    // 3: clear small back page (page 0), swap, read everything back
    run_clear(8'h3C, 1'b0, "t3");
    swap_now("t3_swap");
    read_burst(SM, 1'b0, "t3_read");

    // 4: swap requested and frame_start seen during a clear
    c2 = 8'($urandom_range(1, 254));
    run_clear(c2, 1'b1, "t4");
    check("t4_pend_after", 32'(s_swap_pending), 32'd1);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    check("t4_front", 32'(s_front_page),   32'(front_m ^ 1));
    check("t4_done",  32'(s_swap_done),    32'd1);
    check("t4_pend",  32'(s_swap_pending), 32'd0);
    front_m ^= 1;
    read_burst(SM, 1'b0, "t4_read");

    // 5: two requests, one frame_start, one toggle only
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    tick();
    swap_req = 1'b1;
    tick();
    swap_req = 1'b0;
    check("t5_pend", 32'(s_swap_pending), 32'd1);
    frame_start = 1'b1;
    tick();
    check("t5_front", 32'(s_front_page), 32'(front_m ^ 1));
    check("t5_done",  32'(s_swap_done),  32'd1);
    front_m ^= 1;
    tick();
    frame_start = 1'b0;
    check("t5_front_once", 32'(s_front_page), 32'(front_m));
    check("t5_done_once",  32'(s_swap_done),  32'd0);

    // Random writes to the back page, swap, random reads
    for (int i = 0; i < 40; i++) begin
      wr_en     = ($urandom_range(0, 4) != 0);
      a         = $urandom_range(0, SM - 1);
      s_wr_addr = 5'(a);
      wr_data   = 8'($urandom);
      if (wr_en) mem_m[(1 - front_m) * SM + a] = wr_data;
      tick();
    end
    wr_en = 1'b0;
    swap_now("rnd_swap");
    read_burst(60, 1'b1, "rnd_read");

    // 6: reset in the middle of a clear, then a fresh clear
    s_clear_req = 1'b1; clear_color = 8'h55;
    tick();
    s_clear_req = 1'b0;
    repeat (9) tick();
    check("t6_busy_mid", 32'(s_clear_busy), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_busy",  32'(s_clear_busy),   32'd0);
    check("t6_ready", 32'(s_wr_ready),     32'd1);
    check("t6_front", 32'(s_front_page),   32'd0);
    check("t6_pend",  32'(s_swap_pending), 32'd0);
    check("t6_valid", 32'(s_pixel_valid),  32'd0);
    check("t6_pixel", 32'(s_pixel_data),   32'h00);
    tick();
    rst = 1'b1;
    front_m = 0;
    tick();
    run_clear(8'h81, 1'b0, "t6");
    swap_now("t6_swap");
    read_burst(SM, 1'b0, "t6_read");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
